module_demux_iq_pair: RTL and testbench
=======================================

Name: module_demux_iq_pair

Overview:
- Receive-side counterpart of the post-decimation mux/clock-adjust stage.
- Consumes the time-multiplexed sample stream (Data, Valid, ChIdx) and re-pairs I and Q beats into one parallel I/Q word with a single valid pulse.
- Sits between the mux clock-adjust output and downstream per-channel processing (FFT/record packer).
- Detects and flags pairing faults: orphan Q, duplicate I, and Q timeout.

Parameters:
- INPUT_WIDTH, 24: width of Data_In, signed.
- OUTPUT_WIDTH, 24: width of each I/Q output, signed; must satisfy OUTPUT_WIDTH <= INPUT_WIDTH.
- PAIR_TIMEOUT, 28: maximum CLK cycles allowed between an I beat and its Q beat; 0 disables the timeout.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- nRST  in  1  asynchronous active-low reset.
- Data_In  in  INPUT_WIDTH  signed muxed sample.
- Data_In_Valid  in  1  beat qualifier; every high cycle is one beat.
- Data_In_ChIdx  in  4  0 = invalid, 1 = I, 2 = Q, 3..15 = reserved.
- Data_I_Out  out  OUTPUT_WIDTH  paired I sample.
- Data_Q_Out  out  OUTPUT_WIDTH  paired Q sample.
- Data_IQ_Valid  out  1  one-cycle pulse when a pair is presented.
- Pair_Err  out  1  one-cycle pulse on a pairing fault.
- Err_Code  out  2  01 = orphan Q, 10 = duplicate I, 11 = timeout; holds the last code.
- Err_Cnt  out  8  saturating fault count.
- Pair_Cnt  out  16  wrapping count of emitted pairs.

Behaviour:
- Interface: one clock CLK; reset nRST is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; timer 0; I holding register 0.
- Beat rules: a beat is Data_In_Valid=1 at a posedge. Beats with ChIdx 0 or 3..15 are ignored: no state change, and the timer keeps running.
- State IDLE:
  - I beat: latch width-converted I, clear timer, go to WAIT_Q.
  - Q beat: Pair_Err=1, Err_Code=01, stay in IDLE.
- State WAIT_Q: timer increments each cycle.
  - Q beat: drive Data_I_Out and Data_Q_Out, Data_IQ_Valid=1 on the next cycle (latency 1 from the Q beat), Pair_Cnt+1, go to IDLE.
  - I beat: Pair_Err=1, Err_Code=10, overwrite the held I, clear timer, stay in WAIT_Q.
  - No Q beat: when the timer reaches PAIR_TIMEOUT (and PAIR_TIMEOUT != 0), Pair_Err=1, Err_Code=11, discard I, go to IDLE.
- Simultaneous events: a valid I or Q beat in the same cycle as timer expiry takes precedence; no timeout is flagged.
- Output hold: Data_I_Out and Data_Q_Out hold their value between pulses.
- Pulse widths: Data_IQ_Valid and Pair_Err are exactly one cycle wide. Both can never assert in the same cycle, except a duplicate-I error while a previous pair is still emitting, which cannot occur because the pair output clears WAIT_Q.
- Counters: Err_Cnt saturates at 255. Pair_Cnt wraps from 65535 to 0.
- Width conversion: keep the top OUTPUT_WIDTH bits (truncation toward minus infinity). When OUTPUT_WIDTH == INPUT_WIDTH, pass through unchanged.
- Reset mid-operation: a held I is discarded and no pulse is emitted after reset release.
- Back-to-back beats: I at cycle n and Q at n+1 are legal and produce a pulse at n+2.

Optional Feature:
- Macro: MODULE_DEMUX_IQ_ROUND_EN.
- Defined: width conversion uses round-half-up. Add 2^(INPUT_WIDTH-OUTPUT_WIDTH-1) before the shift, and saturate to the maximum positive OUTPUT_WIDTH value on overflow. The adder is combinational, so latency stays 1. No effect when widths are equal.
- Undefined: plain truncation as above.

Test Plan:
- Pair: reset, I beat 0x100000, then Q beat 0xF00000 two cycles later -> one-cycle Data_IQ_Valid one cycle after Q, I=0x100000, Q=0xF00000, Pair_Cnt=1, Pair_Err=0.
- Orphan Q and ignored beats: Q beat in IDLE, then beat with ChIdx=0, then ChIdx=5 -> one Pair_Err pulse, Err_Code=01, Err_Cnt=1; the ignored beats produce nothing.
- Duplicate I: I=5, I=7, Q=9 -> Pair_Err with Err_Code=10 on the second I, then pair emitted with I=7, Q=9.
- Timeout: PAIR_TIMEOUT=28, I beat, no Q -> Pair_Err with Err_Code=11 at timer=28; a Q arriving at timer=28 instead -> pair emitted, no error. A later Q -> orphan.
- Width and rounding: INPUT_WIDTH=24, OUTPUT_WIDTH=16, I=0x7FFF80, Q=0x000080.
  - Without macro: I=0x7FFF, Q=0x0000.
  - With MODULE_DEMUX_IQ_ROUND_EN: I=0x7FFF (saturated), Q=0x0001.
- Saturation, wrap and reset: 300 orphan Qs -> Err_Cnt=255. 65536 pairs -> Pair_Cnt=0. nRST asserted in WAIT_Q -> all outputs 0, no pulse after release.

Source files
------------

// File: rtl/module_demux_iq_pair.sv
// Re-pairs a time-multiplexed I/Q beat stream into one parallel I/Q word and flags pairing faults.
// Optional MODULE_DEMUX_IQ_ROUND_EN selects round-half-up width conversion instead of truncation.
module module_demux_iq_pair #(
    parameter int INPUT_WIDTH  = 24,
    parameter int OUTPUT_WIDTH = 24,
    parameter int PAIR_TIMEOUT = 28
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [INPUT_WIDTH-1:0]  Data_In,
    input  logic                    Data_In_Valid,
    input  logic [3:0]              Data_In_ChIdx,
    output logic [OUTPUT_WIDTH-1:0] Data_I_Out,
    output logic [OUTPUT_WIDTH-1:0] Data_Q_Out,
    output logic                    Data_IQ_Valid,
    output logic                    Pair_Err,
    output logic [1:0]              Err_Code,
    output logic [7:0]              Err_Cnt,
    output logic [15:0]             Pair_Cnt
);

    typedef enum logic {IDLE = 1'b0, WAIT_Q = 1'b1} state_t;

    localparam logic [1:0] ERR_ORPHAN_Q = 2'b01;
    localparam logic [1:0] ERR_DUP_I    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    // Timer only ever holds 0..PAIR_TIMEOUT-1; expiry is the cycle it would reach PAIR_TIMEOUT.
    localparam int TIMER_W = (PAIR_TIMEOUT < 2) ? 1 : $clog2(PAIR_TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'((PAIR_TIMEOUT == 0) ? 0 : PAIR_TIMEOUT - 1);

`ifdef MODULE_DEMUX_IQ_ROUND_EN
    localparam int SHIFT = INPUT_WIDTH - OUTPUT_WIDTH;
    localparam logic [INPUT_WIDTH:0] ROUND_BIAS = (INPUT_WIDTH + 1)'((1 << SHIFT) >> 1);
`endif

    function automatic logic [OUTPUT_WIDTH-1:0] convert(input logic [INPUT_WIDTH-1:0] din);
`ifdef MODULE_DEMUX_IQ_ROUND_EN
        logic [INPUT_WIDTH:0] sum;
        // One guard bit catches the only overflow possible: a positive value rounding past max.
        sum = {din[INPUT_WIDTH-1], din} + ROUND_BIAS;
        if (sum[INPUT_WIDTH] != sum[INPUT_WIDTH-1])
            convert = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
        else
            convert = sum[INPUT_WIDTH-1 -: OUTPUT_WIDTH];
`else
        convert = din[INPUT_WIDTH-1 -: OUTPUT_WIDTH];
`endif
    endfunction

    state_t                  state, state_nxt;
    logic [TIMER_W-1:0]      timer, timer_nxt;
    logic [OUTPUT_WIDTH-1:0] i_hold, i_hold_nxt;
    logic [OUTPUT_WIDTH-1:0] i_out_nxt, q_out_nxt;
    logic                    iq_valid_nxt, pair_err_nxt;
    logic [1:0]              err_code_nxt;
    logic [7:0]              err_cnt_nxt;
    logic [15:0]             pair_cnt_nxt;

    logic is_i, is_q, timeout_hit;

    assign is_i        = Data_In_Valid && (Data_In_ChIdx == 4'd1);
    assign is_q        = Data_In_Valid && (Data_In_ChIdx == 4'd2);
    assign timeout_hit = (PAIR_TIMEOUT != 0) && (timer == TIMER_LAST);

    always_comb begin
        // NOTE: every target is given a default first, so no branch can leave a latch behind.
        state_nxt    = state;
        timer_nxt    = timer;
        i_hold_nxt   = i_hold;
        i_out_nxt    = Data_I_Out;
        q_out_nxt    = Data_Q_Out;
        iq_valid_nxt = 1'b0;
        pair_err_nxt = 1'b0;
        err_code_nxt = Err_Code;
        err_cnt_nxt  = Err_Cnt;
        pair_cnt_nxt = Pair_Cnt;

        case (state)
            IDLE: begin
                if (is_i) begin
                    i_hold_nxt = convert(Data_In);
                    timer_nxt  = '0;
                    state_nxt  = WAIT_Q;
                end else if (is_q) begin
                    pair_err_nxt = 1'b1;
                    err_code_nxt = ERR_ORPHAN_Q;
                end
            end
            WAIT_Q: begin
                // Beats win over a coincident expiry, so they are tested first.
                if (is_q) begin
                    i_out_nxt    = i_hold;
                    q_out_nxt    = convert(Data_In);
                    iq_valid_nxt = 1'b1;
                    pair_cnt_nxt = Pair_Cnt + 16'd1;
                    timer_nxt    = '0;
                    state_nxt    = IDLE;
                end else if (is_i) begin
                    pair_err_nxt = 1'b1;
                    err_code_nxt = ERR_DUP_I;
                    i_hold_nxt   = convert(Data_In);
                    timer_nxt    = '0;
                end else if (timeout_hit) begin
                    pair_err_nxt = 1'b1;
                    err_code_nxt = ERR_TIMEOUT;
                    timer_nxt    = '0;
                    state_nxt    = IDLE;
                end else if (PAIR_TIMEOUT != 0) begin
                    timer_nxt = timer + TIMER_W'(1);
                end
            end
        endcase

        if (pair_err_nxt && (Err_Cnt != 8'hFF))
            err_cnt_nxt = Err_Cnt + 8'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state         <= IDLE;
            timer         <= '0;
            i_hold        <= '0;
            Data_I_Out    <= '0;
            Data_Q_Out    <= '0;
            Data_IQ_Valid <= 1'b0;
            Pair_Err      <= 1'b0;
            Err_Code      <= 2'b00;
            Err_Cnt       <= 8'd0;
            Pair_Cnt      <= 16'd0;
        end else begin
            state         <= state_nxt;
            timer         <= timer_nxt;
            i_hold        <= i_hold_nxt;
            Data_I_Out    <= i_out_nxt;
            Data_Q_Out    <= q_out_nxt;
            Data_IQ_Valid <= iq_valid_nxt;
            Pair_Err      <= pair_err_nxt;
            Err_Code      <= err_code_nxt;
            Err_Cnt       <= err_cnt_nxt;
            Pair_Cnt      <= pair_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_module_demux_iq_pair.sv
// Randomised and directed bench for module_demux_iq_pair: a 24->24 and a 24->16 instance share one
// input stream and are checked against a cycle-stamped behavioural pairing model.
module tb_module_demux_iq_pair;

    localparam int TMO = 28;

    logic        CLK;
    logic        nRST;
    logic [23:0] data_in;
    logic        data_valid;
    logic [3:0]  ch_idx;

    logic [23:0] i_out, q_out;
    logic        iq_valid, pair_err;
    logic [1:0]  err_code;
    logic [7:0]  err_cnt;
    logic [15:0] pair_cnt;

    logic [15:0] i16, q16;
    logic        valid16, err16;
    logic [1:0]  code16;
    logic [7:0]  ecnt16;
    logic [15:0] pcnt16;

    module_demux_iq_pair #(.INPUT_WIDTH(24), .OUTPUT_WIDTH(24), .PAIR_TIMEOUT(TMO)) dut (
        .CLK(CLK), .nRST(nRST), .Data_In(data_in), .Data_In_Valid(data_valid),
        .Data_In_ChIdx(ch_idx), .Data_I_Out(i_out), .Data_Q_Out(q_out),
        .Data_IQ_Valid(iq_valid), .Pair_Err(pair_err), .Err_Code(err_code),
        .Err_Cnt(err_cnt), .Pair_Cnt(pair_cnt)
    );

    module_demux_iq_pair #(.INPUT_WIDTH(24), .OUTPUT_WIDTH(16), .PAIR_TIMEOUT(TMO)) dut16 (
        .CLK(CLK), .nRST(nRST), .Data_In(data_in), .Data_In_Valid(data_valid),
        .Data_In_ChIdx(ch_idx), .Data_I_Out(i16), .Data_Q_Out(q16),
        .Data_IQ_Valid(valid16), .Pair_Err(err16), .Err_Code(code16),
        .Err_Cnt(ecnt16), .Pair_Cnt(pcnt16)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    int checks   = 0;
    int failures = 0;

    // Behavioural model: pending I tagged with the cycle it arrived on.
    bit          m_pending;
    logic [23:0] m_i, m_i_out, m_q_out;
    logic [1:0]  m_code;
    int          m_err_cnt, m_pair_cnt;
    bit          exp_valid, exp_err;
    int          cyc, i_cyc;

    function automatic logic [15:0] conv16(input logic [23:0] d);
        logic signed [31:0] s;
        s = 32'(signed'(d));
`ifdef MODULE_DEMUX_IQ_ROUND_EN
        s = (s + 128) >>> 8;
        if (s > 32767) s = 32767;
`else
        s = s >>> 8;
`endif
        return s[15:0];
    endfunction

    task automatic model_reset();
        m_pending = 0; m_i = '0; m_i_out = '0; m_q_out = '0; m_code = 2'b00;
        m_err_cnt = 0; m_pair_cnt = 0; exp_valid = 0; exp_err = 0;
    endtask

    task automatic model_flag(input logic [1:0] code);
        exp_err = 1;
        m_code  = code;
        if (m_err_cnt < 255) m_err_cnt++;
    endtask

    task automatic step(input bit v, input logic [3:0] idx, input logic [23:0] d);
        data_valid = v;
        ch_idx     = idx;
        data_in    = d;
        @(posedge CLK);
        cyc++;
        exp_valid = 0;
        exp_err   = 0;
        if (v && idx == 4'd1) begin
            if (m_pending) model_flag(2'b10);
            m_pending = 1;
            m_i       = d;
            i_cyc     = cyc;
        end else if (v && idx == 4'd2) begin
            if (m_pending) begin
                m_i_out    = m_i;
                m_q_out    = d;
                exp_valid  = 1;
                m_pair_cnt = (m_pair_cnt + 1) % 65536;
                m_pending  = 0;
            end else begin
                model_flag(2'b01);
            end
        end else if (m_pending && TMO != 0 && (cyc - i_cyc) == TMO) begin
            model_flag(2'b11);
            m_pending = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (iq_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", iq_valid); end
        checks++; if (pair_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %0b want 0", pair_err); end
        checks++; if (err_code !== 2'b00) begin failures++; $display("FAIL reset_code: got %0b want 00", err_code); end
        checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL reset_errcnt: got %0d want 0", err_cnt); end
        checks++; if (pair_cnt !== 16'd0) begin failures++; $display("FAIL reset_paircnt: got %0d want 0", pair_cnt); end
        checks++; if (i_out !== 24'd0 || q_out !== 24'd0) begin failures++; $display("FAIL reset_data: got %0h/%0h want 0/0", i_out, q_out); end
        @(negedge CLK);
        nRST = 1'b1;
        model_reset();
    endtask

    task automatic test_pair();
        step(1, 4'd1, 24'h100000);
        checks++; if (iq_valid !== 1'b0) begin failures++; $display("FAIL pair_early_valid: got %0b want 0", iq_valid); end
        step(0, 4'd0, 24'h0);
        step(1, 4'd2, 24'hF00000);
        checks++; if (iq_valid !== 1'b1) begin failures++; $display("FAIL pair_valid: got %0b want 1", iq_valid); end
        checks++; if (i_out !== 24'h100000) begin failures++; $display("FAIL pair_i: got %0h want 100000", i_out); end
        checks++; if (q_out !== 24'hF00000) begin failures++; $display("FAIL pair_q: got %0h want f00000", q_out); end
        checks++; if (pair_cnt !== 16'd1) begin failures++; $display("FAIL pair_cnt: got %0d want 1", pair_cnt); end
        checks++; if (pair_err !== 1'b0) begin failures++; $display("FAIL pair_err: got %0b want 0", pair_err); end
        step(0, 4'd0, 24'h0);
        checks++; if (iq_valid !== 1'b0) begin failures++; $display("FAIL pair_pulse_width: got %0b want 0", iq_valid); end
        checks++; if (i_out !== 24'h100000 || q_out !== 24'hF00000) begin failures++; $display("FAIL pair_hold: got %0h/%0h want 100000/f00000", i_out, q_out); end
    endtask

    task automatic test_orphan_ignored();
        step(1, 4'd2, 24'h123456);
        checks++; if (pair_err !== 1'b1 || err_code !== 2'b01) begin failures++; $display("FAIL orphan_flag: got err=%0b code=%0b want 1/01", pair_err, err_code); end
        checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL orphan_cnt: got %0d want 1", err_cnt); end
        step(1, 4'd0, 24'h111111);
        checks++; if (pair_err !== 1'b0 || iq_valid !== 1'b0) begin failures++; $display("FAIL ignored_idx0: got err=%0b valid=%0b want 0/0", pair_err, iq_valid); end
        step(1, 4'd5, 24'h222222);
        checks++; if (pair_err !== 1'b0 || iq_valid !== 1'b0 || err_cnt !== 8'd1) begin failures++; $display("FAIL ignored_idx5: got err=%0b valid=%0b cnt=%0d want 0/0/1", pair_err, iq_valid, err_cnt); end
    endtask

    task automatic test_dup_i();
        step(1, 4'd1, 24'd5);
        step(1, 4'd1, 24'd7);
        checks++; if (pair_err !== 1'b1 || err_code !== 2'b10) begin failures++; $display("FAIL dup_flag: got err=%0b code=%0b want 1/10", pair_err, err_code); end
        step(1, 4'd2, 24'd9);
        checks++; if (iq_valid !== 1'b1 || i_out !== 24'd7 || q_out !== 24'd9) begin failures++; $display("FAIL dup_pair: got v=%0b i=%0d q=%0d want 1/7/9", iq_valid, i_out, q_out); end
        checks++; if (pair_err !== 1'b0 || pair_cnt !== 16'd2) begin failures++; $display("FAIL dup_after: got err=%0b pcnt=%0d want 0/2", pair_err, pair_cnt); end
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        step(1, 4'd1, 24'h0ABCDE);
        for (int k = 1; k < TMO; k++) begin
            if (k == 10) step(1, 4'd3, 24'h0); else step(0, 4'd0, 24'h0);
            if (pair_err !== 1'b0) early++;
        end
        checks++; if (early != 0) begin failures++; $display("FAIL timeout_early: got %0d errors before expiry want 0", early); end
        step(0, 4'd0, 24'h0);
        checks++; if (pair_err !== 1'b1 || err_code !== 2'b11) begin failures++; $display("FAIL timeout_flag: got err=%0b code=%0b want 1/11", pair_err, err_code); end
        step(1, 4'd2, 24'h000321);
        checks++; if (pair_err !== 1'b1 || err_code !== 2'b01 || iq_valid !== 1'b0) begin failures++; $display("FAIL timeout_late_q: got err=%0b code=%0b v=%0b want 1/01/0", pair_err, err_code, iq_valid); end
        step(1, 4'd1, 24'h000444);
        repeat (TMO - 1) step(0, 4'd0, 24'h0);
        step(1, 4'd2, 24'h000555);
        checks++; if (iq_valid !== 1'b1 || pair_err !== 1'b0 || q_out !== 24'h000555) begin failures++; $display("FAIL timeout_edge_q: got v=%0b err=%0b q=%0h want 1/0/555", iq_valid, pair_err, q_out); end
        step(0, 4'd0, 24'h0);
        checks++; if (pair_err !== 1'b0) begin failures++; $display("FAIL timeout_after_pair: got %0b want 0", pair_err); end
    endtask

    task automatic test_width();
        logic [15:0] e_i, e_q, e_i2, e_q2;
`ifdef MODULE_DEMUX_IQ_ROUND_EN
        e_i = 16'h7FFF; e_q = 16'h0001; e_i2 = 16'h0000; e_q2 = 16'h7FFF;
`else
        e_i = 16'h7FFF; e_q = 16'h0000; e_i2 = 16'hFFFF; e_q2 = 16'h7FFF;
`endif
        step(1, 4'd1, 24'h7FFF80);
        step(1, 4'd2, 24'h000080);
        checks++; if (i16 !== e_i || q16 !== e_q) begin failures++; $display("FAIL width_pos: got %0h/%0h want %0h/%0h", i16, q16, e_i, e_q); end
        checks++; if (i_out !== 24'h7FFF80 || q_out !== 24'h000080) begin failures++; $display("FAIL width_pass: got %0h/%0h want 7fff80/80", i_out, q_out); end
        step(1, 4'd1, 24'hFFFF80);
        step(1, 4'd2, 24'h7FFFFF);
        checks++; if (i16 !== e_i2 || q16 !== e_q2) begin failures++; $display("FAIL width_neg_max: got %0h/%0h want %0h/%0h", i16, q16, e_i2, e_q2); end
    endtask

    task automatic test_random();
        int idle_run, r;
        logic [3:0] idx;
        idle_run = 0;
        for (int n = 0; n < 800; n++) begin
            if (idle_run > 0) begin
                idle_run--;
                step(0, 4'd0, 24'($urandom));
            end else begin
                r = $urandom_range(0, 99);
                if (r < 3) idle_run = $urandom_range(20, 35);
                if (r < 35) idx = 4'd1;
                else if (r < 70) idx = 4'd2;
                else if (r < 80) idx = (r < 75) ? 4'd0 : 4'($urandom_range(3, 15));
                else idx = 4'd0;
                step(r < 80, idx, 24'($urandom));
            end
            checks++; if (iq_valid !== exp_valid || valid16 !== exp_valid) begin failures++; $display("FAIL rnd_valid@%0d: got %0b/%0b want %0b", cyc, iq_valid, valid16, exp_valid); end
            checks++; if (pair_err !== exp_err || err16 !== exp_err) begin failures++; $display("FAIL rnd_err@%0d: got %0b/%0b want %0b", cyc, pair_err, err16, exp_err); end
            checks++; if (err_code !== m_code || code16 !== m_code) begin failures++; $display("FAIL rnd_code@%0d: got %0b/%0b want %0b", cyc, err_code, code16, m_code); end
            checks++; if (err_cnt !== 8'(m_err_cnt) || ecnt16 !== 8'(m_err_cnt)) begin failures++; $display("FAIL rnd_errcnt@%0d: got %0d/%0d want %0d", cyc, err_cnt, ecnt16, m_err_cnt); end
            checks++; if (pair_cnt !== 16'(m_pair_cnt) || pcnt16 !== 16'(m_pair_cnt)) begin failures++; $display("FAIL rnd_paircnt@%0d: got %0d/%0d want %0d", cyc, pair_cnt, pcnt16, m_pair_cnt); end
            checks++; if (i_out !== m_i_out || q_out !== m_q_out) begin failures++; $display("FAIL rnd_data@%0d: got %0h/%0h want %0h/%0h", cyc, i_out, q_out, m_i_out, m_q_out); end
            checks++; if (i16 !== conv16(m_i_out) || q16 !== conv16(m_q_out)) begin failures++; $display("FAIL rnd_data16@%0d: got %0h/%0h want %0h/%0h", cyc, i16, q16, conv16(m_i_out), conv16(m_q_out)); end
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        for (int n = 0; n < 200; n++) begin
            step(1, 4'd1, 24'($urandom));
            if (iq_valid !== 1'b0) bad++;
            step(1, 4'd2, 24'($urandom));
            if (iq_valid !== 1'b1 || i_out !== m_i_out || q_out !== m_q_out || pair_cnt !== 16'(m_pair_cnt)) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL back_to_back: got %0d bad cycles want 0", bad); end
        checks++; if (pair_cnt !== 16'(m_pair_cnt)) begin failures++; $display("FAIL b2b_paircnt: got %0d want %0d", pair_cnt, m_pair_cnt); end
    endtask

    task automatic test_err_saturation();
        repeat (300) step(1, 4'd2, 24'($urandom));
        checks++; if (err_cnt !== 8'd255 || ecnt16 !== 8'd255) begin failures++; $display("FAIL err_saturate: got %0d/%0d want 255", err_cnt, ecnt16); end
        checks++; if (err_code !== 2'b01 || pair_err !== 1'b1) begin failures++; $display("FAIL err_sat_last: got code=%0b err=%0b want 01/1", err_code, pair_err); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        step(1, 4'd1, 24'h345678);
        #2;
        nRST = 1'b0;
        #1;
        checks++; if (iq_valid !== 1'b0 || pair_err !== 1'b0 || err_code !== 2'b00) begin failures++; $display("FAIL midreset_flags: got v=%0b err=%0b code=%0b want 0", iq_valid, pair_err, err_code); end
        checks++; if (err_cnt !== 8'd0 || pair_cnt !== 16'd0 || i_out !== 24'd0 || q_out !== 24'd0) begin failures++; $display("FAIL midreset_regs: got ec=%0d pc=%0d i=%0h q=%0h want 0", err_cnt, pair_cnt, i_out, q_out); end
        @(negedge CLK);
        nRST = 1'b1;
        model_reset();
        repeat (3) begin
            step(0, 4'd0, 24'h0);
            if (iq_valid !== 1'b0 || pair_err !== 1'b0) pulses++;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL midreset_pulse: got %0d pulses want 0", pulses); end
        step(1, 4'd2, 24'h000777);
        checks++; if (pair_err !== 1'b1 || err_code !== 2'b01 || iq_valid !== 1'b0) begin failures++; $display("FAIL midreset_discard: got err=%0b code=%0b v=%0b want 1/01/0", pair_err, err_code, iq_valid); end
    endtask

    initial begin
        nRST       = 1'b0;
        data_in    = '0;
        data_valid = 1'b0;
        ch_idx     = 4'd0;
        cyc        = 0;
        i_cyc      = 0;
        model_reset();
        test_reset();
        test_pair();
        test_orphan_ignored();
        test_dup_i();
        test_timeout();
        test_width();
        test_random();
        test_back_to_back();
        test_err_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
